// File: rtl/instr_fetch_unit.sv
// Fetch stage for the non-pipelined RV32 core: owns the PC, addresses I_memory
// and registers each instruction towards decode behind a valid/ready handshake.
module instr_fetch_unit #(
    parameter int                   Addr_bits = 32,
    parameter int                   Word_size = 32,
    parameter logic [Addr_bits-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [Addr_bits-1:0] imem_addr,
    input  logic [Word_size-1:0] imem_instr,
    input  logic                 redirect_valid,
    input  logic [Addr_bits-1:0] redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [Addr_bits-1:0] out_pc,
    output logic [Word_size-1:0] out_instr,
    output logic                 halted,
    output logic                 fetch_err,
    output logic [31:0]          retire_cnt
);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    localparam logic [Word_size-1:0] NOP    = Word_size'(32'h0000_0013);
    localparam logic [Word_size-1:0] EBREAK = Word_size'(32'h0010_0073);
    localparam logic [Addr_bits-1:0] STEP   = Addr_bits'(4);

    logic [1:0]           state;
    logic [Addr_bits-1:0] pc;
    logic                 load;
    logic                 accept;
    logic                 aligned;

    assign imem_addr = {2'b00, pc[Addr_bits-1:2]};
    assign halted    = (state == HALT);
    assign accept    = out_valid && out_ready;
    assign load      = !out_valid || out_ready;
    assign aligned   = (redirect_pc[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_instr  <= NOP;
            fetch_err  <= 1'b0;
            retire_cnt <= '0;
        end else begin
            // A handshake completes even when a redirect flushes the same cycle.
            if (accept) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN, HALT: begin
                    if (redirect_valid) begin
                        out_valid <= 1'b0;
                        if (aligned) begin
                            pc    <= redirect_pc;
                            state <= RUN;
                        end else begin
                            fetch_err <= 1'b1;
                            state     <= ERR;
                        end
                    end else if (state == RUN) begin
                        if (load) begin
                            out_instr <= imem_instr;
                            out_pc    <= pc;
                            out_valid <= 1'b1;
                            pc        <= pc + STEP;
                            if (imem_instr == EBREAK) begin
                                state <= HALT;
                            end
                        end
                    end else if (accept) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    fetch_err <= 1'b1;
                end
            endcase
        end
    end

endmodule
